// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ps
// serial_adder_ctrl: bit-serial adder around one full-adder cell and a carry flop, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port and a - b - cin (borrow-in) support.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, b_load;
    logic [CW-1:0]    cnt;
    logic             carry, carry_load, s_bit, c_bit, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_bit  = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    // Subtraction is a + ~b + ~cin, so only the load values of b and carry differ.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? ~cin : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
            carry  <= c_bit;
            // Outputs only update on the final bit so they stay stable through RUN.
            if (cnt == LAST) begin
                sum  <= {s_bit, sum_sh[WIDTH-1:1]};
                cout <= c_bit;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
`timescale 1ns/1ps
// Bench for serial_adder_ctrl: directed corner cases and random ops checked
// against an arithmetic reference model.
module tb_serial_adder_ctrl;
    localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         in_ready, out_valid, cout, busy;
    logic [W-1:0] sum;

    int           errors = 0;
    int           checks = 0;
    logic [W:0]   lastRes = '0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {carry-out / no-borrow, result mod 2^W} from plain integer arithmetic.
    function automatic logic [W:0] refModel(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic cv, input logic sv);
        longint     t;
        logic [W:0] r;
        if (sv) t = longint'(av) - longint'(bv) - longint'(cv);
        else    t = longint'(av) + longint'(bv) + longint'(cv);
        r[W] = sv ? (t >= 0) : (t >= (longint'(1) << W));
        if (t < 0) t += longint'(1) << W;
        r[W-1:0] = W'(t);
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the output handshake.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic sv, input int hold);
        logic [W:0] exp;
        int         n;
        exp = refModel(av, bv, cv, sv);
        n = 0;
        while (!in_ready && n < 4*W) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_idle", 64'(in_ready), 64'(1));
        a = av; b = bv; cin = cv;
`ifdef SERIAL_ADDER_SUB_EN
        sub = sv;
`endif
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'($urandom);
`endif
        @(negedge clk);
        checkOutput("run_in_ready", 64'(in_ready), 64'(0));
        checkOutput("run_busy", 64'(busy), 64'(1));
        checkOutput("run_result_held", 64'({cout, sum}), 64'(lastRes));
        n = 0;
        while (!out_valid && n < 4*W) begin
            @(negedge clk);
            n++;
        end
        checkOutput("latency", 64'(n), 64'(W));
        checkOutput("result", 64'({cout, sum}), 64'(exp));
        checkOutput("done_in_ready", 64'(in_ready), 64'(0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom);
            checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
            checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
            checkOutput("bp_result_stable", 64'({cout, sum}), 64'(exp));
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("idle_out_valid", 64'(out_valid), 64'(0));
        checkOutput("idle_in_ready", 64'(in_ready), 64'(1));
        checkOutput("idle_busy", 64'(busy), 64'(0));
        checkOutput("idle_result_held", 64'({cout, sum}), 64'(exp));
        lastRes  = exp;
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_result", 64'({cout, sum}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0, 0);
        applyStimulus(8'h12, 8'h34, 1'b1, 1'b0, 5);

        // Abort a run at cnt=3 with an asynchronous reset between edges.
        a = 8'h33; b = 8'h44; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 64'(out_valid), 64'(0));
        checkOutput("abort_in_ready", 64'(in_ready), 64'(1));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_result", 64'({cout, sum}), 64'(0));
        @(negedge clk);
        rst_n   = 1'b1;
        lastRes = '0;
        @(negedge clk);
        applyStimulus(8'h80, 8'h80, 1'b1, 1'b0, 0);

        for (int i = 0; i < 10; i++)
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom),
                          SUB_EN ? 1'($urandom) : 1'b0, 0);

        if (SUB_EN) begin
            applyStimulus(8'h10, 8'h01, 1'b0, 1'b1, 0);
            applyStimulus(8'h00, 8'h01, 1'b0, 1'b1, 0);
            applyStimulus(8'h00, 8'h00, 1'b1, 1'b1, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
